vx_tex_texel_addr: RTL and testbench

- Texel address generator: turns per-lane integer texel coordinates into memory word addresses and byte offsets.
- Consumes the per-format log2 texel stride (bytes per texel) from the texture stride lookup stage.
- Sits between the coordinate wrap/scale stage and the texture memory request stage.
- Two-stage elastic pipeline with valid/ready handshake on both sides; throughput one request per cycle.

---
 rtl/vx_tex_texel_addr_if.sv | 39 +++
 rtl/vx_tex_texel_addr.sv | 114 +++++++++++
 tb/tb_vx_tex_texel_addr.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vx_tex_texel_addr_if.sv
// Request/response bundle for the texel address generator.
// master = upstream/downstream environment, slave = the address generator.
interface vx_tex_texel_addr_if #(
  parameter int NUM_LANES     = 4,
  parameter int COORD_BITS    = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int TAG_WIDTH     = 8,
  parameter int LGSTRIDE_BITS = 2,
  parameter int LOGSIZE_BITS  = 4
);
  logic                              req_valid;
  logic                              req_ready;
  logic [NUM_LANES-1:0]              req_mask;
  logic [TAG_WIDTH-1:0]              req_tag;
  logic [ADDR_WIDTH-1:0]             req_baddr;
  logic [LOGSIZE_BITS-1:0]           req_logwidth;
  logic [LGSTRIDE_BITS-1:0]          req_log_stride;
  logic [NUM_LANES*COORD_BITS-1:0]   req_u;
  logic [NUM_LANES*COORD_BITS-1:0]   req_v;

  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [NUM_LANES-1:0]              rsp_mask;
  logic [TAG_WIDTH-1:0]              rsp_tag;
  logic [NUM_LANES*(ADDR_WIDTH-2)-1:0] rsp_addr;
  logic [NUM_LANES*2-1:0]            rsp_offset;

  modport master (
    output req_valid, req_mask, req_tag, req_baddr, req_logwidth,
           req_log_stride, req_u, req_v, rsp_ready,
    input  req_ready, rsp_valid, rsp_mask, rsp_tag, rsp_addr, rsp_offset
  );

  modport slave (
    input  req_valid, req_mask, req_tag, req_baddr, req_logwidth,
           req_log_stride, req_u, req_v, rsp_ready,
    output req_ready, rsp_valid, rsp_mask, rsp_tag, rsp_addr, rsp_offset
  );
endinterface

// File: rtl/vx_tex_texel_addr.sv
// Texel address generator: per-lane (u,v) -> word address + byte offset.
// S0 forms the linear texel index, S1 scales it by the texel stride and
// adds the mip base. Two-entry elastic pipeline, one request per cycle.
module vx_tex_texel_addr #(
  parameter int NUM_LANES     = 4,
  parameter int COORD_BITS    = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int TAG_WIDTH     = 8,
  parameter int LGSTRIDE_BITS = 2,
  parameter int LOGSIZE_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_tex_texel_addr_if.slave   bus
);
  localparam int WORD_BITS = ADDR_WIDTH - 2;

  logic                          s0_valid;
  logic [NUM_LANES-1:0]          s0_mask;
  logic [TAG_WIDTH-1:0]          s0_tag;
  logic [ADDR_WIDTH-1:0]         s0_baddr;
  logic [LGSTRIDE_BITS-1:0]      s0_log_stride;

  logic                          s1_valid;
  logic [NUM_LANES-1:0]          s1_mask;
  logic [TAG_WIDTH-1:0]          s1_tag;

  logic                          s1_adv;
  logic                          accept;

  // S1 takes new data when it is empty or being drained this cycle;
  // req_ready depends only on registered state and rsp_ready.
  assign s1_adv        = s0_valid && (!s1_valid || bus.rsp_ready);
  assign bus.req_ready = !s0_valid || s1_adv;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = s1_valid;
  assign bus.rsp_mask  = s1_mask;
  assign bus.rsp_tag   = s1_tag;

  // Shared control and per-request fields of both stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid      <= 1'b0;
      s0_mask       <= '0;
      s0_tag        <= '0;
      s0_baddr      <= '0;
      s0_log_stride <= '0;
      s1_valid      <= 1'b0;
      s1_mask       <= '0;
      s1_tag        <= '0;
    end else begin
      if (accept) begin
        s0_valid      <= 1'b1;
        s0_mask       <= bus.req_mask;
        s0_tag        <= bus.req_tag;
        s0_baddr      <= bus.req_baddr;
        s0_log_stride <= bus.req_log_stride;
      end else if (s1_adv) begin
        s0_valid      <= 1'b0;
      end

      if (s1_adv) begin
        s1_valid <= 1'b1;
        s1_mask  <= s0_mask;
        s1_tag   <= s0_tag;
      end else if (bus.rsp_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [ADDR_WIDTH-1:0] u_ext;
      logic [ADDR_WIDTH-1:0] v_ext;
      logic [ADDR_WIDTH-1:0] idx_next;
      logic [ADDR_WIDTH-1:0] idx;
      logic [ADDR_WIDTH-1:0] byte_addr;
      logic [WORD_BITS-1:0]  addr;
      logic [1:0]            offset;

      assign u_ext     = ADDR_WIDTH'(bus.req_u[gi*COORD_BITS +: COORD_BITS]);
      assign v_ext     = ADDR_WIDTH'(bus.req_v[gi*COORD_BITS +: COORD_BITS]);
      // Row-major linear texel index; wraps modulo 2^ADDR_WIDTH.
      assign idx_next  = (v_ext << bus.req_logwidth) + u_ext;
      assign byte_addr = s0_baddr + (idx << s0_log_stride);

      // S0 index register, loaded on accept.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          idx <= '0;
        end else if (accept) begin
          idx <= idx_next;
        end
      end

      // S1 address/offset register; inactive lanes are zeroed.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          addr   <= '0;
          offset <= '0;
        end else if (s1_adv) begin
          addr   <= s0_mask[gi] ? byte_addr[ADDR_WIDTH-1:2] : '0;
          offset <= s0_mask[gi] ? byte_addr[1:0] : 2'b00;
        end
      end

      assign bus.rsp_addr[gi*WORD_BITS +: WORD_BITS] = addr;
      assign bus.rsp_offset[gi*2 +: 2]               = offset;
    end
  endgenerate
endmodule

// File: tb/tb_vx_tex_texel_addr.sv
// Self-checking bench for vx_tex_texel_addr: directed cases, randomized
// traffic with backpressure, and a mid-flight reset, against an
// arithmetic reference model and an in-order scoreboard.
module tb_vx_tex_texel_addr;
  localparam int NL = 4, CB = 16, AW = 32, TW = 8, LSB = 2, LGB = 4;
  localparam int WA = AW - 2;

  typedef struct {
    logic [NL-1:0]    mask;
    logic [TW-1:0]    tag;
    logic [NL*WA-1:0] addr;
    logic [NL*2-1:0]  off;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_tex_texel_addr_if #(.NUM_LANES(NL), .COORD_BITS(CB), .ADDR_WIDTH(AW),
    .TAG_WIDTH(TW), .LGSTRIDE_BITS(LSB), .LOGSIZE_BITS(LGB)) bus ();

  vx_tex_texel_addr #(.NUM_LANES(NL), .COORD_BITS(CB), .ADDR_WIDTH(AW),
    .TAG_WIDTH(TW), .LGSTRIDE_BITS(LSB), .LOGSIZE_BITS(LGB)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int   checks = 0;
  int   failures = 0;
  int   n_acc;
  bit   last_acc, last_drn;
  exp_t sb[$];

  task automatic chk(string name, logic [127:0] obs, logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // Reference: byte = baddr + (v*2^lw + u)*2^ls, everything mod 2^32.
  function automatic logic [31:0] ref_byte(logic [31:0] ba, int lw, int ls,
                                           longint unsigned u, longint unsigned v);
    longint unsigned idx, b;
    idx = (v * (64'd1 << lw) + u) % (64'd1 << 32);
    b   = (longint'(ba) + idx * (64'd1 << ls)) % (64'd1 << 32);
    return b[31:0];
  endfunction

  task automatic drive(logic [3:0] m, logic [7:0] t, logic [31:0] ba,
                       logic [3:0] lw, logic [1:0] ls, logic [63:0] u, logic [63:0] v);
    bus.req_valid      = 1'b1;
    bus.req_mask       = m;
    bus.req_tag        = t;
    bus.req_baddr      = ba;
    bus.req_logwidth   = lw;
    bus.req_log_stride = ls;
    bus.req_u          = u;
    bus.req_v          = v;
  endtask

  // One clock: observe handshakes just after the falling edge, score them,
  // then advance to the next falling edge.
  task automatic step();
    exp_t e;
    logic [31:0] b;
    #1;
    last_acc = bus.req_valid && bus.req_ready;
    last_drn = bus.rsp_valid && bus.rsp_ready;
    if (last_drn) begin
      chk("rsp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_tag", bus.rsp_tag, e.tag);
        chk("rsp_mask", bus.rsp_mask, e.mask);
        chk("rsp_addr", bus.rsp_addr, e.addr);
        chk("rsp_offset", bus.rsp_offset, e.off);
      end
    end
    if (last_acc) begin
      e.mask = bus.req_mask;
      e.tag  = bus.req_tag;
      e.addr = '0;
      e.off  = '0;
      for (int i = 0; i < NL; i++) begin
        if (bus.req_mask[i]) begin
          b = ref_byte(bus.req_baddr, int'(bus.req_logwidth), int'(bus.req_log_stride),
                       longint'(bus.req_u[i*CB +: CB]), longint'(bus.req_v[i*CB +: CB]));
          e.addr[i*WA +: WA] = b[31:2];
          e.off[i*2 +: 2]    = b[1:0];
        end
      end
      sb.push_back(e);
      $display("tb: accept tag=0x%0h mask=0x%0h", e.tag, e.mask);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(4'h0, 8'h0, 32'h0, 4'h0, 2'h0, 64'h0, 64'h0);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_rsp_mask", bus.rsp_mask, 0);
    chk("rst_rsp_addr", bus.rsp_addr, 0);
    chk("rst_rsp_offset", bus.rsp_offset, 0);
    reset = 1'b0;
    @(negedge clk);

    // Stride 2, latency of two cycles
    drive(4'hF, 8'h10, 32'h1000, 4'd4, 2'd2, {4{16'd3}}, {4{16'd2}});
    step();
    chk("s2_accept", last_acc, 1);
    bus.req_valid = 1'b0;
    chk("s2_lat_n1", bus.rsp_valid, 0);
    step();
    chk("s2_lat_n2", bus.rsp_valid, 1);
    chk("s2_addr", bus.rsp_addr[0 +: WA], 30'h423);
    chk("s2_offset", bus.rsp_offset[1:0], 2'd0);
    step();

    // Stride 1 and stride 0, back to back
    drive(4'hF, 8'h21, 32'h2000, 4'd0, 2'd1, {4{16'd5}}, 64'h0);
    step();
    drive(4'hF, 8'h22, 32'h2000, 4'd0, 2'd0, {4{16'd7}}, 64'h0);
    step();
    bus.req_valid = 1'b0;
    chk("s1_addr", bus.rsp_addr[0 +: WA], 30'h802);
    chk("s1_offset", bus.rsp_offset[1:0], 2'd2);
    step();
    chk("s0_addr", bus.rsp_addr[0 +: WA], 30'h801);
    chk("s0_offset", bus.rsp_offset[1:0], 2'd3);
    step();

    // Backpressure: three requests against a 5-cycle stall
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    drive(4'hF, 8'd1, 32'h3000, 4'd3, 2'd1, {16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8});
    for (int c = 0; c < 5; c++) begin
      step();
      if (last_acc) begin
        n_acc++;
        bus.req_tag = bus.req_tag + 8'd1;
      end
    end
    chk("bp_accepts", n_acc, 2);
    chk("bp_req_ready", bus.req_ready, 0);
    chk("bp_frozen_valid", bus.rsp_valid, 1);
    chk("bp_frozen_tag", bus.rsp_tag, 8'd1);
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_rel_drain1", last_drn, 1);
    chk("bp_rel_accept3", last_acc, 1);
    bus.req_valid = 1'b0;
    step();
    chk("bp_rel_drain2", last_drn, 1);
    step();
    chk("bp_rel_drain3", last_drn, 1);
    chk("bp_sb_empty", sb.size(), 0);

    // Address wrap past 2^32
    drive(4'hF, 8'h40, 32'hFFFF_FFF0, 4'd0, 2'd2, {4{16'd8}}, 64'h0);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("wrap_addr", bus.rsp_addr[0 +: WA], 30'h4);
    chk("wrap_offset", bus.rsp_offset[1:0], 2'd0);
    step();

    // Lane mask: lane 1 inactive
    drive(4'b1101, 8'h50, 32'h4000, 4'd2, 2'd3, {4{16'd1}}, {4{16'd3}});
    step();
    bus.req_valid = 1'b0;
    step();
    chk("mask_rsp_mask", bus.rsp_mask, 4'b1101);
    chk("mask_lane1_addr", bus.rsp_addr[WA +: WA], 30'h0);
    chk("mask_lane1_off", bus.rsp_offset[3:2], 2'd0);
    chk("mask_lane0_addr", bus.rsp_addr[0 +: WA], 30'h101A);
    step();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom), 8'($urandom), $urandom, 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) step();
    chk("rand_drain_done", sb.size(), 0);

    // Reset with two requests in flight
    bus.rsp_ready = 1'b0;
    drive(4'hF, 8'h61, 32'h5000, 4'd1, 2'd1, {4{16'd9}}, {4{16'd9}});
    step();
    drive(4'hF, 8'h62, 32'h6000, 4'd1, 2'd1, {4{16'd9}}, {4{16'd9}});
    step();
    bus.req_valid = 1'b0;
    chk("rst_mid_before", bus.rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", bus.rsp_valid, 0);
    chk("rst_mid_ready", bus.req_ready, 1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("rst_after_ready", bus.req_ready, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rst_no_stale", bus.rsp_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
